// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the multi-channel clock/tick generator.
//   div_t      : divisor / high-time counter word
//   ch_cfg_t   : per-channel {div, high} configuration payload
//   ch_state_t : channel enable FSM states
//   clamp_cfg  : forces a config into the always-toggling legal range
//   calc_def_div : reset divisor from input clock and default output frequency
package clk_gen_pkg;

  localparam int unsigned CG_DIV_W = 20;

  typedef logic [CG_DIV_W-1:0] div_t;

  typedef struct packed {
    div_t div;
    div_t high;
  } ch_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ch_state_t;

  // Legal range: div >= 2 and 1 <= high <= div-1, so every period has both phases.
  function automatic ch_cfg_t clamp_cfg(input ch_cfg_t c);
    ch_cfg_t r;
    r = c;
    if (r.div < div_t'(2)) r.div = div_t'(2);
    if (r.high == '0) r.high = div_t'(1);
    if (r.high >= r.div) r.high = r.div - div_t'(1);
    return r;
  endfunction

  function automatic int unsigned calc_def_div(input int unsigned clk_hz,
                                               input int unsigned freq_hz);
    return clk_hz / freq_hz;
  endfunction

endpackage

// File: rtl/clk_gen_channel.sv
// One divider channel: period counter, active + shadow config, enable FSM.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   wr, wr_cfg   : shadow-config write strobe and payload (already decoded)
//   en           : run enable (level)
//   clk_out      : registered divided clock
//   tick         : one-cycle pulse on the clk_out rising cycle
//   cfg_pend     : shadow written but not yet applied
module clk_gen_channel
  import clk_gen_pkg::*;
#(
  parameter int unsigned DEF_DIV = 500_000
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    wr,
  input  ch_cfg_t wr_cfg,
  input  logic    en,
  output logic    clk_out,
  output logic    tick,
  output logic    cfg_pend
);

  localparam ch_cfg_t DEF_CFG = clamp_cfg('{div: div_t'(DEF_DIV), high: div_t'(DEF_DIV / 2)});

  ch_state_t state;
  div_t      cnt;
  ch_cfg_t   act_cfg;
  ch_cfg_t   shd_cfg;
  logic      wrap_c;

  // cnt holds the phase index that the next edge presents on clk_out.
  assign wrap_c = (cnt == act_cfg.div - div_t'(1));

  // Counter, config apply and enable FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      act_cfg  <= DEF_CFG;
      shd_cfg  <= DEF_CFG;
      cfg_pend <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (state == ST_IDLE && !en) begin
        // Parked: output low, pending config takes effect straight away.
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
        if (cfg_pend) begin
          act_cfg  <= clamp_cfg(shd_cfg);
          cfg_pend <= 1'b0;
        end
      end else begin
        // Running (or starting from idle at cnt=0, which gives the immediate rise).
        clk_out <= (cnt < act_cfg.high);
        tick    <= (cnt == '0);
        if (wrap_c) begin
          cnt   <= '0;
          state <= en ? ST_RUN : ST_IDLE;
          if (cfg_pend) begin
            act_cfg  <= clamp_cfg(shd_cfg);
            cfg_pend <= 1'b0;
          end
        end else begin
          cnt   <= cnt + div_t'(1);
          state <= en ? ST_RUN : ST_DRAIN;
        end
      end
      // A write on the apply edge lands in the shadow and stays pending.
      if (wr) begin
        shd_cfg  <= wr_cfg;
        cfg_pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_clk_gen.sv
// N-channel programmable clock/tick generator.
// Ports:
//   clk, reset          : system clock, asynchronous active-low reset
//   cfg_wr/cfg_ch       : config write strobe and target channel
//   cfg_div/cfg_high    : period and high-time in clk cycles
//   ch_en               : per-channel run enable
//   clk_out/tick        : per-channel divided clock and rising-edge pulse (registered)
//   cfg_pend            : per-channel shadow-config-pending flag (registered)
module multi_clk_gen
  import clk_gen_pkg::*;
#(
  parameter  int unsigned N_CH     = 4,
  parameter  int unsigned DIV_W    = 20,
  parameter  int unsigned CLK_FPGA = 50_000_000,
  parameter  int unsigned DEF_FREQ = 100,
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_high,
  input  logic [N_CH-1:0]  ch_en,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  cfg_pend
);

  localparam int unsigned DEF_DIV = calc_def_div(CLK_FPGA, DEF_FREQ);

  // Elaboration-time sanity checks.
  if (DIV_W != CG_DIV_W) begin : g_bad_width
    $error("multi_clk_gen: DIV_W must equal clk_gen_pkg::CG_DIV_W");
  end
  if (64'(DEF_DIV) >= (64'd1 << DIV_W)) begin : g_bad_def_div
    $error("multi_clk_gen: DEF_DIV does not fit in DIV_W bits");
  end

  ch_cfg_t wr_cfg_c;
  assign wr_cfg_c = '{div: div_t'(cfg_div), high: div_t'(cfg_high)};

  // Address decode; channel indices >= N_CH match nothing and are dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr_sel_c;
    assign wr_sel_c = cfg_wr && (32'(cfg_ch) == 32'(i));

    clk_gen_channel #(
      .DEF_DIV(DEF_DIV)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr_sel_c),
      .wr_cfg   (wr_cfg_c),
      .en       (ch_en[i]),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .cfg_pend (cfg_pend[i])
    );
  end

endmodule

// File: tb/tb_multi_clk_gen.sv
// Directed bench for multi_clk_gen: 3 channels, default divisor 2000/100 = 20.
module tb_multi_clk_gen;

  localparam int unsigned N_CH  = 3;
  localparam int unsigned DIV_W = 20;
  localparam int unsigned CH_W  = 2;

  logic             clk;
  logic             reset;
  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_high;
  logic [N_CH-1:0]  ch_en;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  cfg_pend;

  int n_vec = 0;
  int n_err = 0;

  multi_clk_gen #(
    .N_CH(N_CH), .DIV_W(DIV_W), .CLK_FPGA(2000), .DEF_FREQ(100)
  ) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .ch_en(ch_en),
    .clk_out(clk_out), .tick(tick), .cfg_pend(cfg_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (at negedges) for the next 0->1 transition of clk_out[ch].
  task automatic wait_rise(input int ch, output bit ok);
    logic prev;
    ok = 1'b0;
    prev = clk_out[ch];
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!prev && clk_out[ch]) begin
        ok = 1'b1;
        return;
      end
      prev = clk_out[ch];
    end
  endtask

  // From the current sample (a rise) count one full period up to the next rise.
  task automatic count_to_rise(input int ch, output int hi, output int per,
                               output int tk, output int t0);
    logic prev;
    hi = 0; per = 0; tk = 0;
    t0 = int'(tick[ch]);
    for (int k = 0; k < 100; k++) begin
      per++;
      hi += int'(clk_out[ch]);
      tk += int'(tick[ch]);
      prev = clk_out[ch];
      @(negedge clk);
      if (!prev && clk_out[ch]) return;
    end
    per = -1;
  endtask

  task automatic wait_pend_clear(input int ch, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!cfg_pend[ch]) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic period_check(input string tag, input int ch, input int e_hi, input int e_per);
    int hi, per, tk, t0;
    count_to_rise(ch, hi, per, tk, t0);
    check_vec({tag, "_high"}, hi, e_hi);
    check_vec({tag, "_period"}, per, e_per);
    check_vec({tag, "_ticks"}, tk, 1);
    check_vec({tag, "_tick_at_rise"}, t0, 1);
  endtask

  task automatic cfg_write(input int ch, input int dv, input int hv);
    cfg_wr   = 1'b1;
    cfg_ch   = CH_W'(ch);
    cfg_div  = DIV_W'(dv);
    cfg_high = DIV_W'(hv);
  endtask

  initial begin
    bit ok;
    int hi, per, tk, t0, hcnt, tcnt;

    reset = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0;
    ch_en = 3'b111;

    // 1: reset state, then defaults (period 20, high 10) on every channel
    repeat (3) @(negedge clk);
    check_vec("rst_clk_out", int'(clk_out), 0);
    check_vec("rst_tick", int'(tick), 0);
    check_vec("rst_pend", int'(cfg_pend), 0);
    reset = 1'b1;
    @(negedge clk);
    check_vec("start_clk_out", int'(clk_out), 7);
    check_vec("start_tick", int'(tick), 7);
    period_check("def_ch0", 0, 10, 20);
    period_check("def_ch1", 1, 10, 20);
    period_check("def_ch2", 2, 10, 20);

    // 2: ch1 div=10 high=3 written mid high phase
    wait_rise(1, ok); check_vec("t2_rise_ok", int'(ok), 1);
    repeat (5) @(negedge clk);
    cfg_write(1, 10, 3);
    @(negedge clk);
    cfg_wr = 1'b0;
    check_vec("t2_pend_set", int'(cfg_pend), 2);
    count_to_rise(1, hi, per, tk, t0);
    check_vec("t2_old_tail_high", hi, 4);
    check_vec("t2_old_tail_len", per, 14);
    check_vec("t2_pend_clear", int'(cfg_pend[1]), 0);
    period_check("t2_new", 1, 3, 10);

    // 3: clamping (0,0)->(2,1) and (5,9)->(5,4)
    cfg_write(1, 0, 0);
    @(negedge clk);
    cfg_wr = 1'b0;
    wait_pend_clear(1, ok); check_vec("t3a_pend_ok", int'(ok), 1);
    wait_rise(1, ok); check_vec("t3a_rise_ok", int'(ok), 1);
    period_check("t3_clamp_min", 1, 1, 2);
    cfg_write(1, 5, 9);
    @(negedge clk);
    cfg_wr = 1'b0;
    wait_pend_clear(1, ok); check_vec("t3b_pend_ok", int'(ok), 1);
    wait_rise(1, ok); check_vec("t3b_rise_ok", int'(ok), 1);
    period_check("t3_clamp_high", 1, 4, 5);

    // 4: disable ch2 at cnt=2 of div=8, stopped apply, re-enable
    cfg_write(2, 8, 4);
    @(negedge clk);
    cfg_wr = 1'b0;
    wait_pend_clear(2, ok); check_vec("t4_pend_ok", int'(ok), 1);
    wait_rise(2, ok); check_vec("t4_rise_ok", int'(ok), 1);
    repeat (2) @(negedge clk);
    ch_en[2] = 1'b0;
    hcnt = 0; tcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      hcnt += int'(clk_out[2]);
      tcnt += int'(tick[2]);
    end
    check_vec("t4_drain_high", hcnt, 1);
    check_vec("t4_drain_ticks", tcnt, 0);
    check_vec("t4_parked", int'(clk_out[2]), 0);
    cfg_write(2, 6, 2);
    @(negedge clk);
    cfg_wr = 1'b0;
    check_vec("t4_idle_pend_set", int'(cfg_pend[2]), 1);
    @(negedge clk);
    check_vec("t4_idle_pend_applied", int'(cfg_pend[2]), 0);
    ch_en[2] = 1'b1;
    @(negedge clk);
    check_vec("t4_reen_clk_out", int'(clk_out[2]), 1);
    check_vec("t4_reen_tick", int'(tick[2]), 1);
    period_check("t4_reen", 2, 2, 6);

    // 5: last write wins, out-of-range channel ignored
    wait_rise(0, ok); check_vec("t5_rise_ok", int'(ok), 1);
    cfg_write(0, 6, 3);
    @(negedge clk);
    cfg_write(0, 12, 5);
    @(negedge clk);
    cfg_write(3, 4, 2);
    @(negedge clk);
    cfg_wr = 1'b0;
    check_vec("t5_pend_only_ch0", int'(cfg_pend), 1);
    wait_pend_clear(0, ok); check_vec("t5_pend_ok", int'(ok), 1);
    wait_rise(0, ok); check_vec("t5_rise0_ok", int'(ok), 1);
    period_check("t5_ch0", 0, 5, 12);
    wait_rise(1, ok); check_vec("t5_rise1_ok", int'(ok), 1);
    period_check("t5_ch1_keep", 1, 4, 5);
    wait_rise(2, ok); check_vec("t5_rise2_ok", int'(ok), 1);
    period_check("t5_ch2_keep", 2, 2, 6);

    // 5b: write landing on the wrap edge stays pending for the next period
    wait_rise(1, ok); check_vec("t5b_rise_ok", int'(ok), 1);
    cfg_write(1, 7, 2);
    @(negedge clk);
    cfg_wr = 1'b0;
    repeat (2) @(negedge clk);
    cfg_write(1, 9, 3);
    @(negedge clk);
    cfg_wr = 1'b0;
    check_vec("t5b_pend_after_wrap", int'(cfg_pend[1]), 1);
    wait_rise(1, ok); check_vec("t5b_rise2_ok", int'(ok), 1);
    period_check("t5b_first", 1, 2, 7);
    period_check("t5b_second", 1, 3, 9);

    // 6: async reset mid high phase drops outputs and pending writes
    wait_rise(0, ok); check_vec("t6_rise_ok", int'(ok), 1);
    @(negedge clk);
    cfg_write(1, 3, 1);
    @(negedge clk);
    cfg_wr = 1'b0;
    check_vec("t6_pre_pend", int'(cfg_pend), 2);
    check_vec("t6_pre_high", int'(clk_out[0]), 1);
    reset = 1'b0;
    #1;
    check_vec("t6_rst_clk_out", int'(clk_out), 0);
    check_vec("t6_rst_tick", int'(tick), 0);
    check_vec("t6_rst_pend", int'(cfg_pend), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_vec("t6_restart_clk_out", int'(clk_out), 7);
    period_check("t6_def_ch1", 1, 10, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
